// File: rtl/uart_wb_master_pkg.sv
// Shared UART initiator definitions: register address width, FSM encoding and timeout default.
// Also provides UART_ADDR_WIDTH as a macro for modules that size ports from it.
`ifndef UART_ADDR_WIDTH
`define UART_ADDR_WIDTH 5
`endif

package uart_wb_master_pkg;

    typedef enum logic [1:0] {
        WBM_IDLE   = 2'd0,
        WBM_ACCESS = 2'd1,
        WBM_RESP   = 2'd2
    } wbm_state_t;

    localparam int UART_WBM_TIMEOUT_DEFAULT = 255;

    function automatic int timer_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/uart_wbm_timer.sv
// Access watchdog for the UART Wishbone initiator: loads on clear, counts down while enabled,
// flags expiry in the last permitted strobe cycle.
module uart_wbm_timer
    import uart_wb_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = UART_WBM_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = timer_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // The count reaches zero during the final cycle the strobe may stay high.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= LOAD_VAL;
        end else if (clear) begin
            count <= LOAD_VAL;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/uart_wb_master.sv
// Wishbone initiator for the UART register file: one command in, one classic cycle, one response out.
// Optional access timeout is built when UART_WBM_TIMEOUT_EN is defined.
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// ACCESS | cyc/stb driven, waiting for wb_ack_i (or timeout)
// RESP   | response held until rsp_ready
module uart_wb_master
    import uart_wb_master_pkg::*;
#(
    parameter int uart_data_width = 8,
    parameter int uart_addr_width = `UART_ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES  = UART_WBM_TIMEOUT_DEFAULT
) (
    input  logic                       clk,
    input  logic                       wb_rst_i,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_we,
    input  logic [uart_addr_width-1:0] cmd_addr,
    input  logic [uart_data_width-1:0] cmd_wdata,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [uart_data_width-1:0] rsp_rdata,
    output logic                       rsp_err,
    output logic                       wb_cyc_o,
    output logic                       wb_stb_o,
    output logic                       wb_we_o,
    output logic [uart_addr_width-1:0] wb_addr_o,
    output logic [uart_data_width-1:0] wb_dat_o,
    input  logic [uart_data_width-1:0] wb_dat_i,
    input  logic                       wb_ack_i
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("uart_wb_master: TIMEOUT_CYCLES must be at least 2");
    end

    wbm_state_t state;
    logic       cmd_fire;

    assign cmd_fire = cmd_valid & cmd_ready;
    assign wb_stb_o = wb_cyc_o;

`ifdef UART_WBM_TIMEOUT_EN
    logic timer_clear;
    logic timer_enable;
    logic timer_expired;
    logic rsp_err_q;

    assign timer_clear  = (state == WBM_IDLE);
    assign timer_enable = (state == WBM_ACCESS) && !wb_ack_i;

    uart_wbm_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (wb_rst_i),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (wb_rst_i) begin
            state     <= WBM_IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            wb_cyc_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            wb_addr_o <= '0;
            wb_dat_o  <= '0;
`ifdef UART_WBM_TIMEOUT_EN
            rsp_err_q <= 1'b0;
`endif
        end else begin
            case (state)
                WBM_IDLE: begin
                    if (cmd_fire) begin
                        cmd_ready <= 1'b0;
                        wb_cyc_o  <= 1'b1;
                        wb_we_o   <= cmd_we;
                        wb_addr_o <= cmd_addr;
                        wb_dat_o  <= cmd_wdata;
                        state     <= WBM_ACCESS;
                    end
                end
                WBM_ACCESS: begin
                    // An ack on the expiry edge still completes the transfer normally.
                    if (wb_ack_i) begin
                        wb_cyc_o  <= 1'b0;
                        wb_we_o   <= 1'b0;
                        rsp_rdata <= wb_we_o ? '0 : wb_dat_i;
                        rsp_valid <= 1'b1;
`ifdef UART_WBM_TIMEOUT_EN
                        rsp_err_q <= 1'b0;
`endif
                        state     <= WBM_RESP;
                    end
`ifdef UART_WBM_TIMEOUT_EN
                    else if (timer_expired) begin
                        wb_cyc_o  <= 1'b0;
                        wb_we_o   <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_valid <= 1'b1;
                        rsp_err_q <= 1'b1;
                        state     <= WBM_RESP;
                    end
`endif
                end
                WBM_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= WBM_IDLE;
                    end
                end
                default: begin
                    state     <= WBM_IDLE;
                    cmd_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    wb_cyc_o  <= 1'b0;
                    wb_we_o   <= 1'b0;
                end
            endcase
        end
    end

endmodule
